// File: rtl/neosd_card_cmd_rx_if.sv
// Command hand-off between the SD CMD-line receiver and the card-model FSM.
// The receiver holds cmd_valid and the payload stable until the consumer raises cmd_ack.
interface neosd_card_cmd_rx_if;
    logic        cmd_valid;
    logic        cmd_ack;
    logic [5:0]  cmd_idx;
    logic [31:0] cmd_arg;
    logic        crc_err;
    logic        frame_err;

    modport master (
        output cmd_valid,
        output cmd_idx,
        output cmd_arg,
        output crc_err,
        output frame_err,
        input  cmd_ack
    );

    modport slave (
        input  cmd_valid,
        input  cmd_idx,
        input  cmd_arg,
        input  crc_err,
        input  frame_err,
        output cmd_ack
    );
endinterface

// File: rtl/neosd_card_cmd_rx.sv
// Card-side SD CMD-line receiver: oversamples sd_clk/sd_cmd, deframes 48-bit host
// commands, checks CRC7 and framing, and hands index/argument over a valid/ack slot.
module neosd_card_cmd_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        en_i,
    input  logic                        sd_clk_i,
    input  logic                        sd_cmd_i,
    neosd_card_cmd_rx_if.master         cmd_if,
    output logic                        overrun_o,
    input  logic                        overrun_clr_i,
    output logic                        busy_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // CRC7, generator x^7 + x^3 + 1, one bit per call, MSB first.
    function automatic logic [6:0] crc7_upd(input logic [6:0] crc, input logic b);
        logic fb;
        fb = crc[6] ^ b;
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    // Shift register holds bits 1..47: [46] transmission bit, [0] end bit.
    function automatic logic frame_bad(input logic [46:0] sr);
        return ~sr[46] | ~sr[0];
    endfunction

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] cmd_sync_q;
    logic                   sd_clk_p0;
    logic                   sd_cmd_p0;
    logic                   sd_clk_p1;
    logic                   rise_p0;

    state_t                 state_q;
    state_t                 state_nxt;
    logic [5:0]             bit_cnt_q;
    logic [6:0]             crc_q;
    logic [46:0]            shreg_q;

    logic                   cmd_valid_q;
    logic [5:0]             cmd_idx_q;
    logic [31:0]            cmd_arg_q;
    logic                   crc_err_q;
    logic                   frame_err_q;
    logic                   overrun_q;

    logic                   start;
    logic                   shift;
    logic                   slot_free;
    logic                   load;
    logic                   ovr_set;

    // ---- stage p0: synchronizers and sd_clk rise detection ----
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            clk_sync_q <= '0;
            cmd_sync_q <= '0;
            sd_clk_p1  <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], sd_clk_i};
            cmd_sync_q <= {cmd_sync_q[SYNC_STAGES-2:0], sd_cmd_i};
            sd_clk_p1  <= sd_clk_p0;
        end
    end

    assign sd_clk_p0 = clk_sync_q[SYNC_STAGES-1];
    assign sd_cmd_p0 = cmd_sync_q[SYNC_STAGES-1];
    assign rise_p0   = sd_clk_p0 & ~sd_clk_p1;

    // ---- stage p1: frame FSM ----
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        if (!en_i) begin
            state_nxt = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (rise_p0 && !sd_cmd_p0) state_nxt = S_RECV;
                S_RECV:  if (rise_p0 && bit_cnt_q == 6'd47) state_nxt = S_DONE;
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // An ack in the DONE cycle frees the slot before the new frame is placed.
    always_comb begin
        busy_o    = (state_q != S_IDLE);
        start     = en_i && (state_q == S_IDLE) && rise_p0 && !sd_cmd_p0;
        shift     = en_i && (state_q == S_RECV) && rise_p0;
        slot_free = !cmd_valid_q || cmd_if.cmd_ack;
        load      = en_i && (state_q == S_DONE) && slot_free;
        ovr_set   = en_i && (state_q == S_DONE) && !slot_free;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            bit_cnt_q <= 6'd0;
        end else if (!en_i || state_q == S_DONE) begin
            bit_cnt_q <= 6'd0;
        end else if (start) begin
            bit_cnt_q <= 6'd1;
        end else if (shift) begin
            bit_cnt_q <= bit_cnt_q + 6'd1;
        end
    end

    // CRC covers start, transmission, index and argument (bits 0..39).
    always_ff @(posedge clk_i) begin
        if (start) begin
            crc_q <= crc7_upd(7'd0, sd_cmd_p0);
        end else if (shift && bit_cnt_q <= 6'd39) begin
            crc_q <= crc7_upd(crc_q, sd_cmd_p0);
        end
        if (shift) begin
            shreg_q <= {shreg_q[45:0], sd_cmd_p0};
        end
    end

    // ---- stage p2: command slot and status ----
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cmd_valid_q <= 1'b0;
            cmd_idx_q   <= 6'd0;
            cmd_arg_q   <= 32'd0;
            crc_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else if (load) begin
            cmd_valid_q <= 1'b1;
            cmd_idx_q   <= shreg_q[45:40];
            cmd_arg_q   <= shreg_q[39:8];
            crc_err_q   <= (shreg_q[7:1] != crc_q);
            frame_err_q <= frame_bad(shreg_q);
        end else if (cmd_if.cmd_ack) begin
            cmd_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            overrun_q <= 1'b0;
        end else if (ovr_set) begin
            overrun_q <= 1'b1;
        end else if (overrun_clr_i) begin
            overrun_q <= 1'b0;
        end
    end

    assign cmd_if.cmd_valid = cmd_valid_q;
    assign cmd_if.cmd_idx   = cmd_idx_q;
    assign cmd_if.cmd_arg   = cmd_arg_q;
    assign cmd_if.crc_err   = crc_err_q;
    assign cmd_if.frame_err = frame_err_q;
    assign overrun_o        = overrun_q;

endmodule

// File: tb/tb_neosd_card_cmd_rx.sv
// Scoreboard bench for neosd_card_cmd_rx: drives host CMD frames at clk_i/8 and
// compares each delivered command against the queued expectation.
module tb_neosd_card_cmd_rx;

    typedef struct packed {
        logic [5:0]  idx;
        logic [31:0] arg;
        logic        crc_err;
        logic        frame_err;
    } rsp_t;

    localparam logic [47:0] CMD0      = 48'h400000000095;
    localparam logic [47:0] CMD8      = 48'h48000001AA87;
    localparam logic [47:0] CMD17     = 48'h510000000055;
    localparam logic [47:0] CMD17_END = 48'h510000000054;
    localparam logic [47:0] CMD17_CRC = 48'h510000000057;

    logic clk_i = 1'b0;
    logic rstn_i = 1'b0;
    logic en_i = 1'b1;
    logic sd_clk_i = 1'b0;
    logic sd_cmd_i = 1'b1;
    logic overrun_clr_i = 1'b0;
    logic overrun_o;
    logic busy_o;

    neosd_card_cmd_rx_if cmd_if ();

    neosd_card_cmd_rx dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .en_i          (en_i),
        .sd_clk_i      (sd_clk_i),
        .sd_cmd_i      (sd_cmd_i),
        .cmd_if        (cmd_if),
        .overrun_o     (overrun_o),
        .overrun_clr_i (overrun_clr_i),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    rsp_t exp_q[$];
    rsp_t exp;
    rsp_t got;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   to;

    function automatic rsp_t observed();
        return {cmd_if.cmd_idx, cmd_if.cmd_arg, cmd_if.crc_err, cmd_if.frame_err};
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // Bit i of the frame is f[47-i]; CMD changes while sd_clk is low.
    task automatic send_bits(input logic [47:0] f, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            sd_cmd_i = f[47-i];
            sd_clk_i = 1'b0;
            cyc(4);
            sd_clk_i = 1'b1;
            cyc(4);
        end
        sd_clk_i = 1'b0;
    endtask

    task automatic wait_valid(output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (cmd_if.cmd_valid === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
            cyc(1);
        end
    endtask

    task automatic ack_pulse();
        cmd_if.cmd_ack = 1'b1;
        cyc(1);
        cmd_if.cmd_ack = 1'b0;
    endtask

    task automatic test_reset();
        cyc(3);
        n_tests++;
        if (cmd_if.cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", cmd_if.cmd_valid); end
        n_tests++;
        if (observed() !== rsp_t'(0)) begin n_fail++; $display("FAIL reset_fields got %h want 0", observed()); end
        n_tests++;
        if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b want 0", overrun_o); end
        n_tests++;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_o); end
        rstn_i = 1'b1;
        cyc(3);
    endtask

    task automatic test_cmd0();
        exp_q.push_back('{idx: 6'd0, arg: 32'd0, crc_err: 1'b0, frame_err: 1'b0});
        send_bits(CMD0, 0, 47);
        wait_valid(to);
        n_tests++;
        if (to) begin n_fail++; $display("FAIL cmd0_valid got timeout want valid"); end
        exp = exp_q.pop_front();
        got = observed();
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL cmd0_fields got %h want %h", got, exp); end
        ack_pulse();
        n_tests++;
        if (cmd_if.cmd_valid !== 1'b0) begin n_fail++; $display("FAIL cmd0_ack_clear got %b want 0", cmd_if.cmd_valid); end
    endtask

    task automatic test_cmd8_hold();
        exp_q.push_back('{idx: 6'd8, arg: 32'h000001AA, crc_err: 1'b0, frame_err: 1'b0});
        send_bits(CMD8, 0, 47);
        wait_valid(to);
        n_tests++;
        if (to) begin n_fail++; $display("FAIL cmd8_valid got timeout want valid"); end
        exp = exp_q.pop_front();
        got = observed();
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL cmd8_fields got %h want %h", got, exp); end
        cyc(10);
        n_tests++;
        if (cmd_if.cmd_valid !== 1'b1 || observed() !== exp) begin
            n_fail++; $display("FAIL cmd8_hold got v=%b %h want v=1 %h", cmd_if.cmd_valid, observed(), exp);
        end
        ack_pulse();
        n_tests++;
        if (cmd_if.cmd_valid !== 1'b0) begin n_fail++; $display("FAIL cmd8_ack_clear got %b want 0", cmd_if.cmd_valid); end
    endtask

    task automatic test_errors();
        logic [47:0] frames [2];
        rsp_t        exps   [2];
        frames[0] = CMD17_END;
        exps[0]   = '{idx: 6'd17, arg: 32'd0, crc_err: 1'b0, frame_err: 1'b1};
        frames[1] = CMD17_CRC;
        exps[1]   = '{idx: 6'd17, arg: 32'd0, crc_err: 1'b1, frame_err: 1'b0};
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(exps[k]);
            send_bits(frames[k], 0, 47);
            sd_cmd_i = 1'b1;
            wait_valid(to);
            n_tests++;
            if (to) begin n_fail++; $display("FAIL err%0d_valid got timeout want valid", k); end
            exp = exp_q.pop_front();
            got = observed();
            n_tests++;
            if (got !== exp) begin n_fail++; $display("FAIL err%0d_fields got %h want %h", k, got, exp); end
            ack_pulse();
        end
    endtask

    task automatic test_back_to_back();
        exp_q.push_back('{idx: 6'd0, arg: 32'd0, crc_err: 1'b0, frame_err: 1'b0});
        send_bits(CMD0, 0, 47);
        wait_valid(to);
        exp = exp_q.pop_front();
        got = observed();
        n_tests++;
        if (to || got !== exp) begin n_fail++; $display("FAIL b2b_first got to=%b %h want %h", to, got, exp); end
        // Second frame must be dropped while the first is pending.
        send_bits(CMD8, 0, 47);
        cyc(10);
        n_tests++;
        if (overrun_o !== 1'b1) begin n_fail++; $display("FAIL b2b_overrun got %b want 1", overrun_o); end
        n_tests++;
        if (cmd_if.cmd_valid !== 1'b1 || observed() !== exp) begin
            n_fail++; $display("FAIL b2b_retained got v=%b %h want v=1 %h", cmd_if.cmd_valid, observed(), exp);
        end
        overrun_clr_i = 1'b1;
        cyc(1);
        overrun_clr_i = 1'b0;
        n_tests++;
        if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun_clr got %b want 0", overrun_o); end
        ack_pulse();

        // Ack lands in the DONE cycle of the second frame: it must load with no overrun.
        exp_q.push_back('{idx: 6'd0, arg: 32'd0, crc_err: 1'b0, frame_err: 1'b0});
        send_bits(CMD0, 0, 47);
        wait_valid(to);
        exp = exp_q.pop_front();
        got = observed();
        n_tests++;
        if (to || got !== exp) begin n_fail++; $display("FAIL b2b_pend got to=%b %h want %h", to, got, exp); end
        exp_q.push_back('{idx: 6'd8, arg: 32'h000001AA, crc_err: 1'b0, frame_err: 1'b0});
        send_bits(CMD8, 0, 46);
        sd_cmd_i = CMD8[0];
        sd_clk_i = 1'b0;
        cyc(4);
        sd_clk_i = 1'b1;
        cyc(3);
        cmd_if.cmd_ack = 1'b1;
        cyc(1);
        cmd_if.cmd_ack = 1'b0;
        cyc(3);
        sd_clk_i = 1'b0;
        cyc(2);
        n_tests++;
        if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL b2b_done_ack_overrun got %b want 0", overrun_o); end
        exp = exp_q.pop_front();
        got = observed();
        n_tests++;
        if (cmd_if.cmd_valid !== 1'b1 || got !== exp) begin
            n_fail++; $display("FAIL b2b_done_ack_load got v=%b %h want v=1 %h", cmd_if.cmd_valid, got, exp);
        end
        ack_pulse();
    endtask

    task automatic test_stall_enable();
        exp_q.push_back('{idx: 6'd17, arg: 32'd0, crc_err: 1'b0, frame_err: 1'b0});
        send_bits(CMD17, 0, 20);
        cyc(200);
        n_tests++;
        if (busy_o !== 1'b1) begin n_fail++; $display("FAIL stall_busy got %b want 1", busy_o); end
        send_bits(CMD17, 21, 47);
        wait_valid(to);
        exp = exp_q.pop_front();
        got = observed();
        n_tests++;
        if (to || got !== exp) begin n_fail++; $display("FAIL stall_fields got to=%b %h want %h", to, got, exp); end
        ack_pulse();

        send_bits(CMD17, 0, 30);
        en_i = 1'b0;
        cyc(1);
        n_tests++;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL en_abort_busy got %b want 0", busy_o); end
        cyc(2);
        en_i = 1'b1;
        sd_cmd_i = 1'b1;
        cyc(30);
        n_tests++;
        if (cmd_if.cmd_valid !== 1'b0) begin n_fail++; $display("FAIL en_abort_valid got %b want 0", cmd_if.cmd_valid); end
        exp_q.push_back('{idx: 6'd0, arg: 32'd0, crc_err: 1'b0, frame_err: 1'b0});
        send_bits(CMD0, 0, 47);
        wait_valid(to);
        exp = exp_q.pop_front();
        got = observed();
        n_tests++;
        if (to || got !== exp) begin n_fail++; $display("FAIL en_after_cmd0 got to=%b %h want %h", to, got, exp); end
        ack_pulse();
    endtask

    task automatic test_async_reset();
        exp_q.push_back('{idx: 6'd8, arg: 32'h000001AA, crc_err: 1'b0, frame_err: 1'b0});
        send_bits(CMD8, 0, 47);
        wait_valid(to);
        exp = exp_q.pop_front();
        got = observed();
        n_tests++;
        if (to || got !== exp) begin n_fail++; $display("FAIL rst_pending got to=%b %h want %h", to, got, exp); end
        send_bits(CMD8, 0, 25);
        #2;
        rstn_i = 1'b0;
        #1;
        n_tests++;
        if (cmd_if.cmd_valid !== 1'b0 || observed() !== rsp_t'(0) || busy_o !== 1'b0 || overrun_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_midframe got v=%b %h busy=%b ovr=%b want all 0",
                     cmd_if.cmd_valid, observed(), busy_o, overrun_o);
        end
        sd_clk_i = 1'b0;
        sd_cmd_i = 1'b1;
        cyc(3);
        rstn_i = 1'b1;
        cyc(3);
        exp_q.push_back('{idx: 6'd8, arg: 32'h000001AA, crc_err: 1'b0, frame_err: 1'b0});
        send_bits(CMD8, 0, 47);
        wait_valid(to);
        exp = exp_q.pop_front();
        got = observed();
        n_tests++;
        if (to || got !== exp) begin n_fail++; $display("FAIL rst_resend got to=%b %h want %h", to, got, exp); end
        ack_pulse();

        // CMD toggling with sd_clk idle low must never start a frame.
        for (int i = 0; i < 20; i++) begin
            sd_cmd_i = ~sd_cmd_i;
            cyc(2);
        end
        sd_cmd_i = 1'b1;
        cyc(5);
        n_tests++;
        if (busy_o !== 1'b0 || cmd_if.cmd_valid !== 1'b0) begin
            n_fail++; $display("FAIL idle_glitch got busy=%b v=%b want 0 0", busy_o, cmd_if.cmd_valid);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_if.cmd_ack = 1'b0;
        test_reset();
        test_cmd0();
        test_cmd8_hold();
        test_errors();
        test_back_to_back();
        test_stall_enable();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
